truth_table_checker: RTL

Hardware-side checker for small combinational test modules. It sequences every input combination onto a DUT and holds each one for a settle period. It then samples the DUT output, compares it against a parameterised expected truth table, and emits one log record per row over a valid/ready handshake. It ends with a pass/fail verdict, so the same check runs on silicon or in a lint-clean synthesizable bench.

---
 rtl/truth_table_checker.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/truth_table_checker.sv
// truth_table_checker: walks every input combination onto a small
// combinational DUT, holds each for SETTLE cycles, samples dut_out,
// compares it with the EXPECTED truth table, emits one log record per
// row over a valid/ready handshake and ends with a pass/fail verdict.
//
// Ports:
//   clk        clock, all state on rising edge
//   rst        synchronous active-high reset
//   start      one-cycle request to begin a run (ignored while busy)
//   stim       stimulus to DUT inputs, bit 0 drives the lowest input
//   dut_out    DUT output under test
//   busy       high from start acceptance until final record handshake
//   done       high after a run completes, until next start or rst
//   pass       verdict, valid when done (err_count == 0)
//   err_count  mismatching rows in the current/last run
//   fail_vec   bit i set if row i mismatched
//   rec_valid  log record available
//   rec_ready  log consumer accepts record
//   rec_idx    stimulus value of the record
//   rec_obs    sampled dut_out
//   rec_exp    EXPECTED[rec_idx]
module truth_table_checker #(
   parameter int unsigned              N_IN     = 2,
   parameter logic [(2**N_IN)-1:0]     EXPECTED = 4'b1000,
   parameter int unsigned              SETTLE   = 20
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   output logic [N_IN-1:0]      stim,
   input  logic                 dut_out,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [N_IN:0]        err_count,
   output logic [(2**N_IN)-1:0] fail_vec,
   output logic                 rec_valid,
   input  logic                 rec_ready,
   output logic [N_IN-1:0]      rec_idx,
   output logic                 rec_obs,
   output logic                 rec_exp
);

   localparam logic [N_IN-1:0] LAST     = N_IN'((2**N_IN) - 1);
   localparam logic [15:0]     CNT_INIT = 16'(SETTLE - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_REPORT
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [15:0] cnt;

   logic accept;
   logic sample;
   logic counting;
   logic hs;
   logic last;
   logic mism;

   // state register
   always_ff @(posedge clk) begin
      if (rst)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE:
            if (start)
               state_nxt = ST_SETTLE;
         ST_SETTLE:
            if (cnt == 16'd0)
               state_nxt = ST_REPORT;
         ST_REPORT:
            if (rec_valid && rec_ready)
               state_nxt = last ? ST_IDLE : ST_SETTLE;
         default:
            state_nxt = ST_IDLE;
      endcase
   end

   // output / control decode
   always_comb begin
      busy     = (state != ST_IDLE);
      accept   = (state == ST_IDLE) && start;
      sample   = (state == ST_SETTLE) && (cnt == 16'd0);
      counting = (state == ST_SETTLE) && (cnt != 16'd0);
      hs       = (state == ST_REPORT) && rec_valid && rec_ready;
      last     = (stim == LAST);
      mism     = (dut_out != EXPECTED[stim]);
   end

   // stim doubles as the row index: it is only forced to 0 once the
   // final record has been accepted, so it never wraps inside a run.
   always_ff @(posedge clk) begin
      if (rst) begin
         stim      <= '0;
         cnt       <= '0;
         done      <= 1'b0;
         pass      <= 1'b0;
         err_count <= '0;
         fail_vec  <= '0;
         rec_valid <= 1'b0;
         rec_idx   <= '0;
         rec_obs   <= 1'b0;
         rec_exp   <= 1'b0;
      end else begin
         unique case (1'b1)
            accept: begin
               stim      <= '0;
               cnt       <= CNT_INIT;
               done      <= 1'b0;
               pass      <= 1'b0;
               err_count <= '0;
               fail_vec  <= '0;
            end
            sample: begin
               rec_valid <= 1'b1;
               rec_idx   <= stim;
               rec_obs   <= dut_out;
               rec_exp   <= EXPECTED[stim];
               if (mism) begin
                  err_count      <= err_count + 1'b1;
                  fail_vec[stim] <= 1'b1;
               end
            end
            hs: begin
               rec_valid <= 1'b0;
               if (last) begin
                  done <= 1'b1;
                  pass <= (err_count == '0);
                  stim <= '0;
               end else begin
                  stim <= stim + 1'b1;
                  cnt  <= CNT_INIT;
               end
            end
            counting:
               cnt <= cnt - 16'd1;
            default: ;
         endcase
      end
   end

endmodule
